// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: transmit end of a 4-phase req/ack clock-domain crossing.
// Holds each accepted word on x_data and raises x_req until the synchronized ack returns.
module cdc_hs_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SYNC_STAGE = 2,
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned TO_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] x_data,
    output logic             x_req,
    input  logic             x_ack,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {StIdle, StSetup, StReq, StRelease} state_e;

    localparam bit              ToEn   = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] ToLast = ToEn ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [TO_W-1:0] ToMax  = TO_W'(TIMEOUT);

    state_e                r_state, w_state_d;
    logic [SYNC_STAGE-1:0] r_ack_sync;
    logic [TO_W-1:0]       r_cnt, w_cnt_d;
    logic                  r_timed_out, w_timed_out_d;
    logic [WIDTH-1:0]      r_data, w_data_d;
    logic                  r_req, w_req_d;
    logic                  r_done, w_done_d;
    logic                  r_to, w_to_d;
    logic                  w_ack_s;
    logic                  w_accept;
    logic                  w_to_hit;

    assign w_ack_s  = r_ack_sync[SYNC_STAGE-1];
    assign w_accept = s_valid & s_ready;
    // r_cnt holds completed REQ cycles, so this is the TIMEOUT-th REQ cycle
    assign w_to_hit = ToEn && (r_cnt == ToLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ack_sync  <= '0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_data      <= '0;
            r_req       <= 1'b0;
            r_done      <= 1'b0;
            r_to        <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ack_sync  <= {r_ack_sync[SYNC_STAGE-2:0], x_ack};
            r_cnt       <= w_cnt_d;
            r_timed_out <= w_timed_out_d;
            r_data      <= w_data_d;
            r_req       <= w_req_d;
            r_done      <= w_done_d;
            r_to        <= w_to_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (w_accept) w_state_d = StSetup;
            StSetup:   w_state_d = StReq;
            StReq:     if (w_ack_s || w_to_hit) w_state_d = StRelease;
            StRelease: if (!w_ack_s) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_data_d      = r_data;
        w_req_d       = r_req;
        w_done_d      = 1'b0;
        w_to_d        = 1'b0;
        w_cnt_d       = '0;
        w_timed_out_d = r_timed_out;
        case (r_state)
            StIdle: begin
                if (w_accept) w_data_d = s_data;
            end
            StSetup: begin
                w_req_d       = 1'b1;
                w_timed_out_d = 1'b0;
            end
            StReq: begin
                w_cnt_d = (r_cnt != ToMax) ? r_cnt + 1'b1 : r_cnt;
                // An ack in the same cycle as the limit wins over the timeout
                if (w_ack_s) begin
                    w_req_d = 1'b0;
                end else if (w_to_hit) begin
                    w_req_d       = 1'b0;
                    w_to_d        = 1'b1;
                    w_timed_out_d = 1'b1;
                end
            end
            StRelease: begin
                if (!w_ack_s) w_done_d = !r_timed_out;
            end
            default: ;
        endcase
    end

    assign s_ready = !rst && (r_state == StIdle) && !w_ack_s;
    assign busy    = (r_state != StIdle);
    assign x_data  = r_data;
    assign x_req   = r_req;
    assign done    = r_done;
    assign timeout = r_to;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: scoreboard bench for cdc_hs_tx with a randomized far-side responder.
// Expected event cycles are computed from the handshake timing rules and checked by a monitor.
module tb_cdc_hs_tx;

    localparam int unsigned W   = 8;
    localparam int unsigned S   = 2;
    localparam int unsigned TO  = 10;
    localparam int unsigned TO5 = 5;
    localparam int          SI  = S;
    localparam int          TOI = TO;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready, x_req, x_ack, busy, done, timeout;
    logic [W-1:0] s_data, x_data;
    logic         s_valid5, s_ready5, x_req5, x_ack5, busy5, done5, timeout5;
    logic [W-1:0] s_data5, x_data5;

    cdc_hs_tx #(.WIDTH(W), .SYNC_STAGE(S), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .x_data(x_data), .x_req(x_req), .x_ack(x_ack), .busy(busy), .done(done),
        .timeout(timeout)
    );

    cdc_hs_tx #(.WIDTH(W), .SYNC_STAGE(S), .TIMEOUT(TO5)) u_dut5 (
        .clk(clk), .rst(rst), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
        .x_data(x_data5), .x_req(x_req5), .x_ack(x_ack5), .busy(busy5), .done(done5),
        .timeout(timeout5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(string name, string what);
        total++;
        bad++;
        $display("FAIL %s: got %s expected none (cycle %0d)", name, what, cyc);
    endfunction

    typedef struct {
        int data;
        int cyc;
    } req_t;

    req_t req_q[$];
    int   fall_q[$];
    int   done_q[$];
    int   to_q[$];
    int   n_done   = 0;
    int   n_resp_w = 0;

    bit resp_en = 1'b0;
    int fix_d1  = 0;
    int fix_d2  = 0;

    // Monitor: pops expectations whenever the DUT shows an event
    bit           mon_en    = 1'b0;
    logic         prev_req  = 1'b0;
    logic         prev_busy = 1'b0;
    logic [W-1:0] prev_data = '0;
    req_t         mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready_while_busy", int'(s_ready && busy), 0);
            if (busy && prev_busy) chk("xdata_hold", x_data, prev_data);
            if (x_req && !prev_req) begin
                if (req_q.size() == 0) flag("req_rise", "unexpected rise");
                else begin
                    mon_e = req_q.pop_front();
                    chk("req_data", x_data, mon_e.data);
                    chk("req_rise_cycle", cyc, mon_e.cyc);
                end
            end
            if (!x_req && prev_req) begin
                if (fall_q.size() == 0) flag("req_fall", "unexpected fall");
                else chk("req_fall_cycle", cyc, fall_q.pop_front());
            end
            if (done) begin
                n_done++;
                if (done_q.size() == 0) flag("done", "unexpected pulse");
                else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("ready_at_done", s_ready, 1);
                end
            end
            if (timeout) begin
                if (to_q.size() == 0) flag("timeout", "unexpected pulse");
                else chk("timeout_cycle", cyc, to_q.pop_front());
            end
        end
        prev_req  = x_req;
        prev_busy = busy;
        prev_data = x_data;
    end

    // Far side: ack d1 cycles after seeing x_req, drop d2 cycles after x_req falls.
    // Request falls on the third edge after the ack (two sync flops, then the registered x_req).
    initial begin : responder
        int d;
        int n;
        forever begin
            @(negedge clk);
            if (resp_en && x_req) begin
                d = (fix_d1 > 0) ? fix_d1 : int'($urandom_range(1, 5));
                repeat (d) @(posedge clk);
                #1 x_ack = 1'b1;
                fall_q.push_back(cyc + SI + 1);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (x_req && n < 100);
                if (x_req) flag("resp_wait", "x_req stuck high");
                d = (fix_d2 > 0) ? fix_d2 : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1 x_ack = 1'b0;
                done_q.push_back(cyc + SI + 1);
            end
        end
    end

    task automatic send_word(input logic [W-1:0] w, input bit last, output int acc);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) flag("accept_wait", "no ready");
        acc = cyc;
        req_q.push_back('{int'(w), cyc + 2});
        @(posedge clk);
        #1;
        if (last) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || x_ack || done_q.size() != 0 || fall_q.size() != 0) && n < 500);
        if (busy || x_ack || done_q.size() != 0 || fall_q.size() != 0) flag("idle_wait", "busy");
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int           a;
        int           t1;
        int           gap;
        logic [W-1:0] w;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        x_ack    = 1'b0;
        s_valid5 = 1'b0;
        s_data5  = '0;
        x_ack5   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_xreq", x_req, 0);
        chk("rst_xdata", x_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ready5", s_ready5, 0);
        chk("rst_xreq5", x_req5, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1);
        @(posedge clk);
        #1;

        // Single word, fixed far-side delays of 3
        resp_en = 1'b1;
        fix_d1  = 3;
        fix_d2  = 3;
        send_word(8'hA5, 1'b1, a);
        n_resp_w++;
        wait_idle();
        fix_d1 = 0;
        fix_d2 = 0;

        // Back-to-back with s_valid held high
        send_word(8'h01, 1'b0, a);
        send_word(8'h02, 1'b0, a);
        send_word(8'h03, 1'b1, a);
        n_resp_w += 3;
        wait_idle();

        // Random words, random gaps and far-side delays
        for (int i = 0; i < 24; i++) begin
            w   = W'($urandom);
            gap = int'($urandom_range(0, 3));
            send_word(w, gap != 0, a);
            n_resp_w++;
            if (gap != 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_idle();

        // No ack at all: x_req high for TO cycles, then a timeout pulse
        resp_en = 1'b0;
        send_word(W'($urandom), 1'b1, a);
        fall_q.push_back(a + 2 + TOI);
        to_q.push_back(a + 2 + TOI);
        repeat (13) @(negedge clk);
        chk("ready_after_timeout", s_ready, 1);
        chk("busy_after_timeout", busy, 0);
        @(posedge clk);
        #1;
        wait_idle();

        // Stale ack while idle blocks acceptance
        x_ack = 1'b1;
        repeat (S) @(posedge clk);
        #1;
        w       = W'($urandom);
        s_data  = w;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stale_ready", s_ready, 0);
            chk("stale_busy", busy, 0);
        end
        @(posedge clk);
        #1 x_ack = 1'b0;
        t1 = cyc;
        for (int k = 0; k < SI; k++) begin
            @(negedge clk);
            chk("stale_ready_hold", s_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stale_ready_back", s_ready, 1);
        chk("stale_ready_cycle", cyc, t1 + SI);
        req_q.push_back('{int'(w), cyc + 2});
        resp_en = 1'b1;
        n_resp_w++;
        @(posedge clk);
        #1 s_valid = 1'b0;
        wait_idle();

        // Reset pulse while in REQ
        resp_en = 1'b0;
        send_word(W'($urandom), 1'b1, a);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        fall_q.push_back(a + 5);
        @(negedge clk);
        chk("rst_req_ready", s_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_xreq", x_req, 0);
        chk("rst_req_xdata", x_data, 0);
        chk("rst_req_busy", busy, 0);
        chk("rst_req_done", done, 0);
        chk("rst_req_timeout", timeout, 0);
        chk("rst_req_ready_back", s_ready, 1);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1;
        wait_idle();

        // TIMEOUT=5 instance: ack_s rises on the 5th REQ cycle
        w        = W'($urandom);
        s_data5  = w;
        s_valid5 = 1'b1;
        t1       = 0;
        @(negedge clk);
        while (!s_ready5 && t1 < 50) begin
            @(negedge clk);
            t1++;
        end
        if (!s_ready5) flag("accept5_wait", "no ready");
        a = cyc;
        @(posedge clk);
        #1 s_valid5 = 1'b0;
        for (int c = a + 1; c <= a + 16; c++) begin
            if (c == a + 4) x_ack5 = 1'b1;
            if (c == a + 9) x_ack5 = 1'b0;
            @(negedge clk);
            chk("co_timeout", timeout5, 0);
            chk("co_done", done5, int'(c == a + 12));
            chk("co_req", x_req5, int'(c >= a + 2 && c <= a + 6));
            chk("co_busy", busy5, int'(c <= a + 11));
            chk("co_data", x_data5, w);
            @(posedge clk);
            #1;
        end

        chk("req_q_empty", req_q.size(), 0);
        chk("fall_q_empty", fall_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        chk("to_q_empty", to_q.size(), 0);
        chk("done_count", n_done, n_resp_w);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
